// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with a valid/ready output handshake.
// Ports:
//   clock, rst          system clock, synchronous active-high reset
//   rx                  asynchronous serial input, idle high
//   divisor             clock cycles per sample tick (0 behaves as 1)
//   parity_type         00/11 none, 01 odd, 10 even
//   stop_bits           0 = one stop bit, 1 = two stop bits
//   data_out/data_valid received word and its valid flag, accepted by data_ready
//   active_flag         high while a frame is in progress
//   error_flag          [0] parity, [1] false start, [2] framing, [3] overrun
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     divisor,
    input  logic [1:0]           parity_type,
    input  logic                 stop_bits,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 active_flag,
    output logic [3:0]           error_flag
);

    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);

    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] FULL_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic                 line_seen_q, line_seen_d;
    logic                 armed_q, armed_d;
    logic [2:0]           state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           ptype_q, ptype_d;
    logic                 stop2_q, stop2_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 active_q, active_d;
    logic [3:0]           err_q, err_d;

    logic                 sample;
    logic                 par_en;
    logic                 par_x;
    logic [DIV_W-1:0]     div_eff;

    // Next-state, datapath and output computation.
    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        // The synchroniser reset value is not an observation of the line.
        line_seen_d = 1'b1;
        armed_d     = armed_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        tick_d      = 1'b0;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        div_d       = div_q;
        ptype_d     = ptype_q;
        stop2_d     = stop2_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        err_d       = err_q;
        sample      = 1'b0;
        par_en      = (ptype_q == 2'b01) || (ptype_q == 2'b10);
        par_x       = ^{shift_q, rx_s_q};
        div_eff     = (div_q == '0) ? DIV_W'(1) : div_q;

        // Tick k lands k*div_eff cycles after START entry (registered pulse).
        if (state_q != S_IDLE) begin
            if (cnt_q == div_eff - DIV_W'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // Mid-bit sample point: half a bit into START, one bit period elsewhere.
        if (tick_q) begin
            if (tcnt_q == ((state_q == S_START) ? HALF_LAST : FULL_LAST)) begin
                sample = 1'b1;
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + TCNT_W'(1);
            end
        end

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (rx_s_q && rx_meta_q && line_seen_q) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                    tick_d  = 1'b0;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    div_d   = divisor;
                    ptype_d = parity_type;
                    stop2_d = stop_bits;
                end
            end
            S_START: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 4'b0010;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bcnt_q == DATA_LAST) begin
                        bcnt_d  = '0;
                        state_d = par_en ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_d  = (ptype_q == 2'b01) ? !par_x : par_x;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end
                    if (stop2_q && (bcnt_q == '0)) begin
                        bcnt_d = BCNT_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!valid_q || data_ready) begin
                    data_out_d = shift_q;
                    valid_d    = 1'b1;
                    err_d      = {1'b0, ferr_q, 1'b0, perr_q};
                end else begin
                    err_d = {1'b1, ferr_q, 1'b0, perr_q};
                end
                // Break: the line is still low, so wait for it to go high again.
                if (ferr_q && !rx_s_q) begin
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            line_seen_q <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            div_q       <= '0;
            ptype_q     <= 2'b00;
            stop2_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 4'b0000;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            line_seen_q <= line_seen_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            ptype_q     <= ptype_d;
            stop2_q     <= stop2_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            err_q       <= err_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = valid_q;
    assign active_flag = active_q;
    assign error_flag  = err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: an 8-bit/16x and a 5-bit/8x instance.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx8, rx5;
    logic [15:0] div8, div5;
    logic [1:0]  pt8, pt5;
    logic        sb8, sb5;
    logic [7:0]  dout8;
    logic [4:0]  dout5;
    logic        dv8, dv5, rdy8, rdy5, act8, act5;
    logic [3:0]  err8, err5;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise8 = 0, rise5 = 0, rise_cyc8 = 0, rise_cyc5 = 0, hs8 = 0;
    logic [7:0] hs_data8 = '0;
    logic dv8_prev = 1'b0, dv5_prev = 1'b0;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) dut8 (
        .clock(clk), .rst(rst), .rx(rx8), .divisor(div8), .parity_type(pt8),
        .stop_bits(sb8), .data_out(dout8), .data_valid(dv8), .data_ready(rdy8),
        .active_flag(act8), .error_flag(err8)
    );

    uart_rx_core #(.DATA_BITS(5), .OVERSAMPLE(8), .DIV_W(16)) dut5 (
        .clock(clk), .rst(rst), .rx(rx5), .divisor(div5), .parity_type(pt5),
        .stop_bits(sb5), .data_out(dout5), .data_valid(dv5), .data_ready(rdy5),
        .active_flag(act5), .error_flag(err5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record data_valid rising edges and handshakes.
    always @(negedge clk) begin
        if (dv8 && !dv8_prev) begin rise8++; rise_cyc8 = cyc; end
        if (dv8 && rdy8) begin hs8++; hs_data8 = dout8; end
        dv8_prev = dv8;
        if (dv5 && !dv5_prev) begin rise5++; rise_cyc5 = cyc; end
        dv5_prev = dv5;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit good_parity(input int unsigned db, input int unsigned data,
                                       input logic [1:0] pt);
        int ones;
        ones = $countones(data & ((32'd1 << db) - 1));
        if (pt == 2'b01) return ((ones % 2) == 0);
        return ((ones % 2) == 1);
    endfunction

    function automatic logic [3:0] exp_err(input int unsigned db, input int unsigned data,
                                           input logic [1:0] pt, input bit sb2, input bit pbit,
                                           input bit s1, input bit s2);
        int ones;
        bit pe, fe;
        ones = $countones(data & ((32'd1 << db) - 1));
        pe = 1'b0;
        if (pt == 2'b01) pe = (((ones + int'(pbit)) % 2) != 1);
        else if (pt == 2'b10) pe = (((ones + int'(pbit)) % 2) != 0);
        fe = !s1 || (sb2 && !s2);
        return {1'b0, fe, 1'b0, pe};
    endfunction

    // Cycles from driving the start bit to data_valid being visible.
    function automatic int exp_lat(input int unsigned os, input int unsigned db,
                                   input logic [1:0] pt, input bit sb2, input int unsigned div);
        int p, s, d;
        p = (pt == 2'b01 || pt == 2'b10) ? 1 : 0;
        s = sb2 ? 2 : 1;
        d = (div == 0) ? 1 : int'(div);
        return 3 + (int'(os) / 2 + (int'(db) + p + s) * int'(os)) * d + 2;
    endfunction

    task automatic set_line(input bit sel5, input logic v);
        if (sel5) rx5 = v; else rx8 = v;
    endtask

    task automatic send_frame(input bit sel5, input int unsigned data, input logic [1:0] pt,
                              input bit sb2, input int unsigned div, input bit pbit,
                              input bit s1, input bit s2, input bit hold_low);
        int unsigned os, db, dur;
        os  = sel5 ? 8 : 16;
        db  = sel5 ? 5 : 8;
        dur = ((div == 0) ? 1 : div) * os;
        @(posedge clk); #1;
        if (sel5) begin div5 = 16'(div); pt5 = pt; sb5 = sb2; end
        else      begin div8 = 16'(div); pt8 = pt; sb8 = sb2; end
        set_line(sel5, 1'b0);
        start_cyc = cyc;
        repeat (dur) @(posedge clk); #1;
        // Scramble configuration mid-frame; the frame must not notice.
        if (sel5) begin div5 = 16'($urandom_range(0, 7)); pt5 = 2'($urandom); sb5 = 1'($urandom); end
        else      begin div8 = 16'($urandom_range(0, 7)); pt8 = 2'($urandom); sb8 = 1'($urandom); end
        for (int i = 0; i < int'(db); i++) begin
            set_line(sel5, 1'((data >> i) & 1));
            repeat (dur) @(posedge clk); #1;
        end
        if (pt == 2'b01 || pt == 2'b10) begin
            set_line(sel5, pbit);
            repeat (dur) @(posedge clk); #1;
        end
        set_line(sel5, s1);
        repeat (dur) @(posedge clk); #1;
        if (sb2) begin
            set_line(sel5, s2);
            repeat (dur) @(posedge clk); #1;
        end
        set_line(sel5, !hold_low);
    endtask

    task automatic run_frame(input bit sel5, input int unsigned data, input logic [1:0] pt,
                             input bit sb2, input int unsigned div, input bit pbit,
                             input bit s1, input bit s2, input bit hold_low);
        int r0;
        int unsigned os, db;
        os = sel5 ? 8 : 16;
        db = sel5 ? 5 : 8;
        r0 = sel5 ? rise5 : rise8;
        send_frame(sel5, data, pt, sb2, div, pbit, s1, s2, hold_low);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("frame_delivered", 32'((sel5 ? rise5 : rise8) - r0), 32'd1);
        check("frame_data", sel5 ? 32'(dout5) : 32'(dout8), data & ((32'd1 << db) - 1));
        check("frame_err", sel5 ? 32'(err5) : 32'(err8),
              32'(exp_err(db, data, pt, sb2, pbit, s1, s2)));
        check("frame_latency", 32'((sel5 ? rise_cyc5 : rise_cyc8) - start_cyc),
              32'(exp_lat(os, db, pt, sb2, div)));
        check("frame_active_low", sel5 ? 32'(act5) : 32'(act8), 32'd0);
    endtask

    initial begin
        int r0;
        int h0;
        bit saw;
        rst = 1'b1; rx8 = 1'b1; rx5 = 1'b1; rdy8 = 1'b1; rdy5 = 1'b1;
        div8 = 16'd4; div5 = 16'd0; pt8 = 2'b00; pt5 = 2'b00; sb8 = 1'b0; sb5 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", 32'(dout8), 32'd0);
        check("reset_valid", 32'(dv8), 32'd0);
        check("reset_active", 32'(act8), 32'd0);
        check("reset_err", 32'(err8), 32'd0);
        check("reset_err5", 32'(err5), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // Basic frame
        run_frame(0, 32'hA5, 2'b00, 0, 4, 0, 1, 1, 0);

        // Even parity, good then bad parity bit
        run_frame(0, 32'h03, 2'b10, 0, 2, 0, 1, 1, 0);
        run_frame(0, 32'h03, 2'b10, 0, 2, 1, 1, 1, 0);

        // Glitch shorter than half a bit
        r0 = rise8;
        @(posedge clk); #1;
        div8 = 16'd4; pt8 = 2'b00; sb8 = 1'b0;
        rx8 = 1'b0;
        repeat (12) @(posedge clk); #1;
        rx8 = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("glitch_err", 32'(err8), 32'h2);
        check("glitch_no_word", 32'(rise8 - r0), 32'd0);
        check("glitch_active", 32'(act8), 32'd0);
        repeat (10) @(posedge clk);

        // Framing errors: one stop bit low, second of two stop bits low
        run_frame(0, 32'h5A, 2'b00, 0, 2, 0, 0, 1, 0);
        repeat (10) @(posedge clk);
        run_frame(0, 32'hC3, 2'b00, 1, 2, 0, 1, 0, 0);
        repeat (10) @(posedge clk);

        // Overrun
        rdy8 = 1'b0;
        r0 = rise8;
        h0 = hs8;
        send_frame(0, 32'h11, 2'b00, 0, 1, 0, 1, 1, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovr_first_valid", 32'(dv8), 32'd1);
        check("ovr_first_data", 32'(dout8), 32'h11);
        check("ovr_first_err", 32'(err8), 32'h0);
        send_frame(0, 32'h22, 2'b00, 0, 1, 0, 1, 1, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovr_data_kept", 32'(dout8), 32'h11);
        check("ovr_err", 32'(err8), 32'h8);
        check("ovr_valid_held", 32'(dv8), 32'd1);
        check("ovr_single_rise", 32'(rise8 - r0), 32'd1);
        @(posedge clk); #1 rdy8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_consumed_valid", 32'(dv8), 32'd0);
        check("ovr_handshakes", 32'(hs8 - h0), 32'd1);
        check("ovr_handshake_data", 32'(hs_data8), 32'h11);
        repeat (10) @(posedge clk);

        // 5-bit, odd parity, two stop bits, divisor 0
        run_frame(1, 32'h1B, 2'b01, 1, 0, good_parity(5, 32'h1B, 2'b01), 1, 1, 0);

        // Break: stop bit low and line held low
        run_frame(0, 32'h3C, 2'b00, 0, 2, 0, 0, 1, 1);
        r0 = rise8;
        saw = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (act8) saw = 1'b1;
        end
        check("break_no_retrigger", 32'(saw), 32'd0);
        check("break_no_word", 32'(rise8 - r0), 32'd0);
        @(posedge clk); #1 rx8 = 1'b1;
        repeat (10) @(posedge clk);
        run_frame(0, 32'h81, 2'b00, 0, 2, 0, 1, 1, 0);

        // Reset during DATA, line held low across and after reset
        @(posedge clk); #1;
        div8 = 16'd4; pt8 = 2'b00; sb8 = 1'b0;
        rx8 = 1'b0;
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("midframe_active", 32'(act8), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_data", 32'(dout8), 32'd0);
        check("rst_mid_valid", 32'(dv8), 32'd0);
        check("rst_mid_active", 32'(act8), 32'd0);
        check("rst_mid_err", 32'(err8), 32'd0);
        r0 = rise8;
        saw = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (act8) saw = 1'b1;
        end
        check("rst_low_no_frame", 32'(saw), 32'd0);
        check("rst_low_no_word", 32'(rise8 - r0), 32'd0);
        @(posedge clk); #1 rx8 = 1'b1;
        repeat (10) @(posedge clk);
        run_frame(0, 32'h5A, 2'b00, 0, 2, 0, 1, 1, 0);

        // Randomized frames on both instances
        for (int n = 0; n < 16; n++) begin
            bit sel5, sb2, pbit, s1, s2;
            int unsigned data, div;
            logic [1:0] pt;
            sel5 = (n % 4) == 3;
            data = $urandom;
            pt   = 2'($urandom);
            sb2  = 1'($urandom);
            div  = $urandom_range(0, 3);
            pbit = good_parity(sel5 ? 5 : 8, data, pt) ^ (($urandom % 4) == 0);
            s1   = ($urandom % 6) != 0;
            s2   = ($urandom % 6) != 0;
            run_frame(sel5, data, pt, sb2, div, pbit, s1, s2, 0);
            repeat (6) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised, oversampling UART receiver for the serial link, replacing the fixed 8-bit receive path in the next generation of the design. It handles configurable data width, a run-time baud divisor, parity mode and 1 or 2 stop bits, and checks the middle of each bit. It hands each received word to downstream logic over a valid/ready handshake. It reports parity, start, framing and overrun errors.

## Interface
- DATA_BITS, 8, data bits per frame (5..9), LSB first on the line
- OVERSAMPLE, 16, sample ticks per bit period (even, >= 4)
- DIV_W, 16, width of the baud divisor input
- clock  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial line, idle high
- divisor  in  DIV_W  clock cycles per sample tick; 0 is treated as 1
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits
- data_out  out  DATA_BITS  received word, stable while data_valid is high
- data_valid  out  1  word available
- data_ready  in  1  consumer accepts the word when data_valid && data_ready
- active_flag  out  1  high while a frame is being received
- error_flag  out  4  [0] parity, [1] start (false start), [2] stop (framing), [3] overrun

## Operation
- rx passes through a 2-flop synchroniser (reset value 1), giving rx_s.
- Armed flag:
  - cleared by reset; set when rx_s = 1.
  - A start is accepted only when armed and rx_s falls from 1 to 0.
  - A line held low never re-triggers.
- Tick counter:
  - counts 0..divisor-1 and pulses a tick on the last count.
  - It is zeroed on entry to START, so the k-th tick falls exactly k*max(divisor,1) cycles after entry.
- At START entry, divisor, parity_type and stop_bits are latched. Input changes mid-frame have no effect on that frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE -> START on an accepted falling edge. active_flag goes high.
  - START: sample rx_s on tick OVERSAMPLE/2.
    - 0 -> DATA.
    - 1 -> false start: error_flag = 4'b0010, no word delivered, -> IDLE.
  - DATA: sample every OVERSAMPLE ticks and shift in LSB first, DATA_BITS samples. Then -> PARITY if parity is enabled, else -> STOP.
  - PARITY: one sample. Odd parity passes when the XOR of data and parity bit is 1; even parity passes when it is 0.
  - STOP: 1 or 2 samples. Any stop sample of 0 is a framing error. After the last sample -> DONE.
  - DONE: one cycle; -> IDLE. active_flag goes low on IDLE entry.
- Delivery in DONE:
  - If the output register is empty or is being consumed this cycle: load data_out, set data_valid, and set error_flag = {0, framing, 0, parity}.
  - Otherwise: the new word is discarded, data_out is unchanged, and error_flag = {1, framing, 0, parity} for the dropped frame.
- error_flag is reloaded only at DONE or at a false start and is held otherwise.
- data_valid clears on the cycle after a handshake, unless DONE reloads it in that same cycle.
- Framing error with rx still low (break): the word is delivered with error_flag[2] = 1. Armed is cleared until rx_s returns high.
- Reset mid-frame:
  - the FSM goes to IDLE and the partial word is discarded;
  - all outputs return to their reset values;
  - armed is cleared.

## Timing
- Reset values:
  - data_out = 0
  - data_valid = 0
  - active_flag = 0
  - error_flag = 0
  - FSM state = IDLE
  - rx synchroniser flops = 1
- rx to rx_s latency is 2 cycles. START entry is 1 cycle after rx_s first reads 0.
- Let P = 1 if parity is enabled (else 0) and S = number of stop bits. The last sample is taken on tick OVERSAMPLE/2 + (DATA_BITS+P+S)*OVERSAMPLE after START entry.
- DONE, and data_valid / error_flag update, occur 1 cycle after the last sample. data_valid is visible the following cycle.
- A new start is accepted on the first cycle back in IDLE. Back-to-back frames are received with no gap beyond the stop bits.
- A handshake and a DONE load in the same cycle is not an overrun.

## Test plan
- Basic frame: DATA_BITS=8, divisor=4, no parity, 1 stop; send 0xA5 with data_ready=1 -> data_out=0xA5, error_flag=0. data_valid rises 152 ticks (608 cycles) + 2 after START entry.
- Parity: even parity, send 0x03 with parity bit 0 -> error_flag=0. Resend with parity bit 1 -> error_flag[0]=1, word still delivered.
- Glitch and framing: a 0 pulse of 3*divisor*OVERSAMPLE/16 cycles on rx -> error_flag=4'b0010, no data_valid. A frame with stop=0 -> error_flag[2]=1. A 2-stop frame with second stop=0 -> error_flag[2]=1.
- Overrun: data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, error_flag[3]=1. Raise data_ready -> 0x11 is consumed, data_valid=0.
- Width/config: DATA_BITS=5, odd parity, 2 stops, divisor=0 (treated as 1); send 5'h1B -> data_out=5'h1B, error_flag=0.
- Reset mid-frame and break: assert rst during DATA -> all outputs 0. Hold rx low after reset release -> no frame until rx returns high and then falls.
